fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Shares the single 1-bit framebuffer write port ({y[8:0],x[9:0]} addressing) among NUM_REQ drawing engines
//  (mouse line drawer, text renderer, shape filler).
//  Contains a built-in full-screen clear sequencer with absolute priority. Sits between the drawing engines and
//  the framebuffer BRAM port A; the display scan-out reads port B and is unaffected.
// PARAMETERS
//  NUM_REQ      3    number of requesters (2..8)
//  H_ACTIVE     640  pixels per line swept by clear
//  V_ACTIVE     480  lines swept by clear
//  CLEAR_VALUE  1'b0 pixel value written by clear
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active-high
//  req          in   NUM_REQ  per-requester write request; held with addr/data until granted
//  req_addr     in   NUM_REQ*19  packed {y[8:0],x[9:0]} per requester, slice i = bits [19*i+18:19*i]
//  req_data     in   NUM_REQ  pixel value per requester
//  gnt          out  NUM_REQ  one-hot, combinational: request i accepted this cycle
//  clear_start  in   1        single-cycle pulse: begin full-screen clear
//  clear_busy   out  1        high while clear sweep in progress
//  clear_done   out  1        single-cycle pulse after last clear write
//  write_addr   out  19       framebuffer address, registered
//  write_enable out  1        framebuffer write strobe, registered
//  write_data   out  1        framebuffer pixel, registered
// BEHAVIOUR
//  - Reset: state=ARB, rr pointer=0, gnt=0, write_enable=0, write_addr=0, write_data=0, clear_busy=0, clear_done=0.
//  - Accept: a request is accepted in cycle t iff req[i]&gnt[i]. Accepted addr/data appear on write_* with
//    write_enable=1 at t+1 (latency 1). Requester may drop or change req/addr/data from t+1.
//  - At most one accept per cycle; throughput 1 write/cycle. No accept: write_enable=0 next cycle, addr/data hold.
//  - States:
//    ARB        grant by arbitration policy; clear_start -> CLEAR (clear_start has priority over any req that cycle:
//               gnt=0).
//    CLEAR      gnt=0; write (x,y) each cycle, x 0..H_ACTIVE-1 inner, y 0..V_ACTIVE-1 outer, data=CLEAR_VALUE.
//               After (H_ACTIVE-1,V_ACTIVE-1) -> CLEAR_DONE.
//    CLEAR_DONE gnt=0, clear_done=1 for this cycle, counters reset to 0 -> ARB.
//  - clear_busy=1 in CLEAR and CLEAR_DONE. clear_start while busy is ignored (no restart).
//  - Clear sweep: H_ACTIVE*V_ACTIVE write cycles; first write (0,0) at clear_start+2, last (639,479) at +307201.
//  - x counter 10-bit, y counter 9-bit; wrap x to 0 and increment y when x==H_ACTIVE-1; no address above 479/639.
//  - Reset mid-clear: abandons sweep immediately, no clear_done, all outputs to reset values next cycle.
//  - Pending requests during clear stall (gnt=0) and are served in ARB afterwards; none are dropped.
// CONFIGURATION
//  FBARB_RR_EN defined: round-robin, search starts at (last granted index+1) mod NUM_REQ; pointer updates only on
//    an accept; continuous requesters alternate.
//  FBARB_RR_EN undefined: fixed priority, lowest index wins; rr pointer register absent.
// STRUCTURE
//  - fb_pkg: FB_X_W=10, FB_Y_W=9, FB_ADDR_W=19, state enum {ARB,CLEAR,CLEAR_DONE}, function fb_addr(x,y).
//  - Sub-module rr_arbiter (req, ptr -> one-hot gnt, granted index); fixed-priority path in-line.
//  - Top: state register, clear x/y counters, rr pointer, output register stage.
// TESTING
//  1. Reset: rst high 3 cycles with req=3'b111 -> gnt=0, write_enable=0, write_addr=0, clear_busy=0.
//  2. Single requester: req=3'b010, addr={9'd5,10'd7}, data=1 -> gnt=3'b010 same cycle; next cycle
//     write_enable=1, write_addr=19'h01407, write_data=1.
//  3. Contention (RR_EN): req=3'b111 held 6 cycles -> gnt sequence 001,010,100,001,010,100; without macro
//     -> 001 every cycle.
//  4. Clear: clear_start pulse with req=3'b001 held -> gnt=0 throughout; exactly 307200 writes, first addr 0,
//     last {9'd479,10'd639}; clear_done one cycle; req 0 granted next cycle.
//  5. clear_start pulsed again at sweep write 1000 -> ignored; total write count still 307200.
//  6. rst asserted at sweep write 5000 -> write_enable=0, clear_busy=0 next cycle; clear_done never pulses.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer write arbiter.
package fb_pkg;

    localparam int unsigned FB_X_W    = 10;
    localparam int unsigned FB_Y_W    = 9;
    localparam int unsigned FB_ADDR_W = 19;

    typedef enum logic [1:0] {
        ARB,
        CLEAR,
        CLEAR_DONE
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic                 data;
    } fb_wr_t;

    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_X_W-1:0] x,
                                                     input logic [FB_Y_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Drawing-engine request bus and framebuffer write port of the arbiter.
interface fb_write_arbiter_if
    import fb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*FB_ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]           req_data;
    logic [NUM_REQ-1:0]           gnt;
    logic                         clear_start;
    logic                         clear_busy;
    logic                         clear_done;
    logic [FB_ADDR_W-1:0]         write_addr;
    logic                         write_enable;
    logic                         write_data;

    modport master (
        output req, req_addr, req_data, clear_start,
        input  gnt, clear_busy, clear_done, write_addr, write_enable, write_data
    );

    modport slave (
        input  req, req_addr, req_data, clear_start,
        output gnt, clear_busy, clear_done, write_addr, write_enable, write_data
    );
endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin requester pick: search starts at ptr and wraps modulo N.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);
    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer port-A write arbiter with a priority full-screen clear sweep.
// Define FBARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic        CLEAR_VALUE = 1'b0
) (
    input logic               clk,
    input logic               rst,
    fb_write_arbiter_if.slave bus
);
    localparam logic [FB_X_W-1:0] X_LAST = FB_X_W'(H_ACTIVE - 1);
    localparam logic [FB_Y_W-1:0] Y_LAST = FB_Y_W'(V_ACTIVE - 1);

    fb_state_e          state;
    logic [FB_X_W-1:0]  clr_x;
    logic [FB_Y_W-1:0]  clr_y;
    fb_wr_t             wr_q;
    logic               we_q;
    logic               busy_q;
    logic               done_q;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [NUM_REQ-1:0] gnt_c;
    logic               acc_c;
    fb_wr_t             sel_c;

`ifdef FBARB_RR_EN
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] arb_idx;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );
`else
    always_comb begin
        arb_gnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req[i] && (arb_gnt == '0)) arb_gnt[i] = 1'b1;
        end
    end
`endif

    // Grants only in ARB; a clear_start that cycle takes the port instead.
    always_comb begin
        gnt_c = (!rst && (state == ARB) && !bus.clear_start) ? arb_gnt : '0;
        acc_c = |gnt_c;
        sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                sel_c.addr = bus.req_addr[i*FB_ADDR_W +: FB_ADDR_W];
                sel_c.data = bus.req_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB;
            clr_x  <= '0;
            clr_y  <= '0;
            wr_q   <= '0;
            we_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef FBARB_RR_EN
            rr_ptr <= '0;
`endif
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                ARB: begin
                    if (acc_c) begin
                        we_q <= 1'b1;
                        wr_q <= sel_c;
`ifdef FBARB_RR_EN
                        rr_ptr <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
                    end
                    if (bus.clear_start) begin
                        state  <= CLEAR;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    we_q      <= 1'b1;
                    wr_q.addr <= fb_addr(clr_x, clr_y);
                    wr_q.data <= CLEAR_VALUE;
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            state  <= CLEAR_DONE;
                            done_q <= 1'b1;
                        end else begin
                            clr_y <= clr_y + 1'b1;
                        end
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
                CLEAR_DONE: begin
                    clr_x  <= '0;
                    clr_y  <= '0;
                    busy_q <= 1'b0;
                    state  <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.write_addr   = wr_q.addr;
    assign bus.write_data   = wr_q.data;
    assign bus.write_enable = we_q;
    assign bus.clear_busy   = busy_q;
    assign bus.clear_done   = done_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized self-checking bench for fb_write_arbiter (reduced clear raster to keep runs short).
module tb_fb_write_arbiter;
    localparam int N  = 3;
    localparam int H  = 40;
    localparam int V  = 30;
    localparam int HV = H * V;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rr_start = 0;

    fb_write_arbiter_if #(.NUM_REQ(N)) bus ();

    fb_write_arbiter #(
        .NUM_REQ     (N),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .CLEAR_VALUE (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference arbitration: which requester the policy should accept.
    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int start);
        int j;
`ifdef FBARB_RR_EN
        for (int k = 0; k < N; k++) begin
            j = (start + k) % N;
            if (r[j]) return N'(1 << j);
        end
`else
        j = start;
        for (int k = 0; k < N; k++) begin
            if (r[k]) return N'(1 << k);
        end
`endif
        return '0;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int k = 0; k < N; k++) if (g[k]) return k;
        return -1;
    endfunction

    function automatic logic [18:0] sweep_addr(input int n);
        return {9'(n / H), 10'(n % H)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 3'b111;
        bus.req_addr = 57'h1_2345_6789_ABCD;
        bus.req_data = 3'b111;
        bus.clear_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (bus.gnt !== 3'b000 || bus.write_enable !== 1'b0 || bus.write_addr !== 19'd0 ||
                bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 || bus.write_data !== 1'b0) begin
                n_fail++;
                $display("FAIL reset: gnt=%b we=%b addr=%h data=%b busy=%b done=%b, required all zero",
                         bus.gnt, bus.write_enable, bus.write_addr, bus.write_data,
                         bus.clear_busy, bus.clear_done);
            end
        end
        bus.req = '0;
        rst = 1'b0;
        rr_start = 0;
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g;
        logic [18:0]  exp_a;
        @(negedge clk);
        bus.req = 3'b111;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*19 +: 19] = {9'(i + 1), 10'(i * 3 + 1)};
            bus.req_data[i] = 1'(i % 2);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_g = model_pick(bus.req, rr_start);
            n_checks++;
            if (bus.gnt !== exp_g) begin
                n_fail++;
                $display("FAIL contention gnt cycle %0d: got %b required %b", c, bus.gnt, exp_g);
            end
            exp_a = {9'(onehot_idx(exp_g) + 1), 10'(onehot_idx(exp_g) * 3 + 1)};
            rr_start = (onehot_idx(exp_g) + 1) % N;
            @(negedge clk);
            n_checks++;
            if (bus.write_enable !== 1'b1 || bus.write_addr !== exp_a) begin
                n_fail++;
                $display("FAIL contention write cycle %0d: we=%b addr=%h required we=1 addr=%h",
                         c, bus.write_enable, bus.write_addr, exp_a);
            end
        end
        bus.req = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req = 3'b010;
        bus.req_addr[19 +: 19] = {9'd5, 10'd7};
        bus.req_data = 3'b010;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b010) begin
            n_fail++;
            $display("FAIL single gnt: got %b required 010", bus.gnt);
        end
        rr_start = 2;
        @(negedge clk);
        bus.req = '0;
        n_checks++;
        if (bus.write_enable !== 1'b1 || bus.write_addr !== 19'h01407 || bus.write_data !== 1'b1) begin
            n_fail++;
            $display("FAIL single write: we=%b addr=%h data=%b required 1 01407 1",
                     bus.write_enable, bus.write_addr, bus.write_data);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pend = '0;
        logic [18:0]  pa [N];
        logic         pd [N];
        logic [N-1:0] exp_g;
        logic [18:0]  ea = '0;
        logic         ed = 1'b0;
        bit           have_exp = 1'b0;
        bit           known = 1'b0;
        int           gi;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            n_checks++;
            if (have_exp) begin
                if (bus.write_enable !== 1'b1 || bus.write_addr !== ea || bus.write_data !== ed) begin
                    n_fail++;
                    $display("FAIL random write cycle %0d: we=%b addr=%h data=%b required 1 %h %b",
                             c, bus.write_enable, bus.write_addr, bus.write_data, ea, ed);
                end
            end else if (bus.write_enable !== 1'b0 || (known && bus.write_addr !== ea)) begin
                n_fail++;
                $display("FAIL random idle cycle %0d: we=%b addr=%h required we=0 addr held %h",
                         c, bus.write_enable, bus.write_addr, ea);
            end
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1;
                    pa[i]   = 19'($urandom);
                    pd[i]   = 1'($urandom);
                end
                bus.req[i] = pend[i];
                bus.req_addr[i*19 +: 19] = pend[i] ? pa[i] : 19'($urandom);
                bus.req_data[i] = pend[i] ? pd[i] : 1'($urandom);
            end
            #1;
            exp_g = model_pick(pend, rr_start);
            n_checks++;
            if (bus.gnt !== exp_g) begin
                n_fail++;
                $display("FAIL random gnt cycle %0d: req=%b got %b required %b", c, pend, bus.gnt, exp_g);
            end
            have_exp = (exp_g != '0);
            if (have_exp) begin
                gi = onehot_idx(exp_g);
                ea = pa[gi];
                ed = pd[gi];
                known = 1'b1;
                pend[gi] = 1'b0;
                rr_start = (gi + 1) % N;
            end
        end
        @(negedge clk);
        bus.req = '0;
        n_checks++;
        if (have_exp && (bus.write_enable !== 1'b1 || bus.write_addr !== ea)) begin
            n_fail++;
            $display("FAIL random final write: we=%b addr=%h required 1 %h",
                     bus.write_enable, bus.write_addr, ea);
        end
    endtask

    // Full sweep with requester 0 stalled; optional ignored re-trigger after restart_at writes.
    task automatic test_clear(input int restart_at);
        int          nw = 0;
        int          ndone = 0;
        logic [18:0] a0 = {9'd3, 10'd4};
        @(negedge clk);
        bus.req = 3'b001;
        bus.req_addr[0 +: 19] = a0;
        bus.req_data = 3'b001;
        bus.clear_start = 1'b1;
        #1;
        n_checks++;
        if (bus.gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL clear start gnt: got %b required 000", bus.gnt);
        end
        for (int k = 1; k <= HV + 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.clear_busy !== ((k <= HV + 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL clear busy k=%0d: got %b", k, bus.clear_busy);
            end
            n_checks++;
            if (bus.clear_done !== ((k == HV + 1) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL clear done k=%0d: got %b", k, bus.clear_done);
            end
            if (bus.clear_done === 1'b1) ndone++;
            if (k == HV + 3) begin
                n_checks++;
                if (bus.write_enable !== 1'b1 || bus.write_addr !== a0 || bus.write_data !== 1'b1) begin
                    n_fail++;
                    $display("FAIL clear post-grant write: we=%b addr=%h required 1 %h",
                             bus.write_enable, bus.write_addr, a0);
                end
            end else begin
                n_checks++;
                if (bus.write_enable !== ((k >= 2 && k <= HV + 1) ? 1'b1 : 1'b0)) begin
                    n_fail++;
                    $display("FAIL clear we k=%0d: got %b", k, bus.write_enable);
                end
                if (bus.write_enable === 1'b1) begin
                    n_checks++;
                    if (bus.write_addr !== sweep_addr(nw) || bus.write_data !== 1'b0) begin
                        n_fail++;
                        $display("FAIL clear sweep write %0d: addr=%h data=%b required %h 0",
                                 nw, bus.write_addr, bus.write_data, sweep_addr(nw));
                    end
                    nw++;
                end
            end
            bus.clear_start = (restart_at >= 0 && nw == restart_at && bus.write_enable === 1'b1);
            if (k == HV + 3) bus.req = '0;
            #1;
            if (k < HV + 3) begin
                n_checks++;
                if (bus.gnt !== ((k == HV + 2) ? 3'b001 : 3'b000)) begin
                    n_fail++;
                    $display("FAIL clear gnt k=%0d: got %b", k, bus.gnt);
                end
            end
        end
        bus.clear_start = 1'b0;
        rr_start = 1;
        n_checks++;
        if (nw != HV || ndone != 1) begin
            n_fail++;
            $display("FAIL clear totals: writes=%0d done=%0d required %0d and 1", nw, ndone, HV);
        end
    endtask

    task automatic test_reset_mid_clear();
        int nw = 0;
        int bud = 0;
        @(negedge clk);
        bus.req = '0;
        bus.clear_start = 1'b1;
        while (nw < 500 && bud < HV + 10) begin
            @(negedge clk);
            bus.clear_start = 1'b0;
            if (bus.write_enable === 1'b1) nw++;
            bud++;
        end
        n_checks++;
        if (nw != 500) begin
            n_fail++;
            $display("FAIL midclear reach: writes=%0d required 500 within budget", nw);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.write_enable !== 1'b0 || bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0 ||
            bus.write_addr !== 19'd0) begin
            n_fail++;
            $display("FAIL midclear reset: we=%b busy=%b done=%b addr=%h required 0 0 0 0",
                     bus.write_enable, bus.clear_busy, bus.clear_done, bus.write_addr);
        end
        rst = 1'b0;
        rr_start = 0;
        repeat (HV / 4) begin
            @(negedge clk);
            n_checks++;
            if (bus.clear_done !== 1'b0 || bus.write_enable !== 1'b0 || bus.clear_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midclear aftermath: done=%b we=%b busy=%b required 0 0 0",
                         bus.clear_done, bus.write_enable, bus.clear_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_random();
        test_clear(-1);
        test_clear(100);
        test_reset_mid_clear();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
